// File: rtl/switch_pkg.sv
// Shared switch-fabric types and width helpers used by the scheduler and the switch top.
package switch_pkg;

  function automatic int calc_src_w(int input_qty);
    return (input_qty > 1) ? $clog2(input_qty) : 1;
  endfunction

  function automatic int calc_dest_w(int output_qty);
    return (output_qty > 1) ? $clog2(output_qty) : 1;
  endfunction

  localparam int DEFAULT_INPUT_QTY  = 8;
  localparam int DEFAULT_OUTPUT_QTY = 8;

  typedef logic [calc_src_w(DEFAULT_INPUT_QTY)-1:0]   src_idx_t;
  typedef logic [calc_dest_w(DEFAULT_OUTPUT_QTY)-1:0] dest_idx_t;

endpackage

// File: rtl/switch_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational winner search from a pointer that advances past each grant.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int SRC_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic             gnt_valid,
  output logic [SRC_W-1:0] gnt_idx
);

  logic [SRC_W-1:0] ptr;
  logic [SRC_W:0]   cand_sum;
  logic [SRC_W-1:0] cand;
  logic             found;

  // Scan ptr, ptr+1, ... with an explicit wrap so N need not be a power of two.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand_sum = {1'b0, ptr} + (SRC_W+1)'(k);
      if (cand_sum >= (SRC_W+1)'(N))
        cand_sum = cand_sum - (SRC_W+1)'(N);
      cand = cand_sum[SRC_W-1:0];
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_valid = en && found;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (gnt_valid)
      ptr <= (gnt_idx == SRC_W'(N-1)) ? '0 : gnt_idx + SRC_W'(1);
  end

endmodule

// File: rtl/switch_rr_scheduler.sv
// Per-output round-robin scheduler: turns FIFO head-of-line destinations into registered
// crossbar selects, FIFO pop pulses and drop pulses for out-of-range destinations.
module switch_rr_scheduler
  import switch_pkg::*;
#(
  parameter int INPUT_QTY  = 8,
  parameter int OUTPUT_QTY = 8,
  parameter int SRC_W      = calc_src_w(INPUT_QTY),
  parameter int DEST_W     = calc_dest_w(OUTPUT_QTY)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [INPUT_QTY-1:0]                 req_valid,
  input  logic [INPUT_QTY-1:0][DEST_W-1:0]     req_dest,
  input  logic [OUTPUT_QTY-1:0]                out_ready,
  output logic [OUTPUT_QTY-1:0]                grant_valid,
  output logic [OUTPUT_QTY-1:0][SRC_W-1:0]     grant_input,
  output logic [INPUT_QTY-1:0]                 deq,
  output logic [INPUT_QTY-1:0]                 drop
);

  logic [INPUT_QTY-1:0]  eff_req;
  logic [INPUT_QTY-1:0]  req_mat [OUTPUT_QTY];
  logic [INPUT_QTY-1:0]  drop_nxt;
  logic [INPUT_QTY-1:0]  deq_nxt;
  logic [OUTPUT_QTY-1:0] win_valid;
  logic [SRC_W-1:0]      win_idx [OUTPUT_QTY];

  // A head whose pop is in flight is masked so it cannot be granted twice.
  assign eff_req = req_valid & ~deq;

  always_comb begin
    drop_nxt = '0;
    for (int o = 0; o < OUTPUT_QTY; o++)
      req_mat[o] = '0;
    for (int i = 0; i < INPUT_QTY; i++) begin
      drop_nxt[i] = eff_req[i] && ({1'b0, req_dest[i]} >= (DEST_W+1)'(OUTPUT_QTY));
      for (int o = 0; o < OUTPUT_QTY; o++)
        req_mat[o][i] = eff_req[i] && (req_dest[i] == DEST_W'(o));
    end
  end

  for (genvar o = 0; o < OUTPUT_QTY; o++) begin : g_out
    rr_arbiter #(
      .N     (INPUT_QTY),
      .SRC_W (SRC_W)
    ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (req_mat[o]),
      .en        (out_ready[o]),
      .gnt_valid (win_valid[o]),
      .gnt_idx   (win_idx[o])
    );
  end

  // Each input targets one destination, so at most one output selects it per cycle.
  always_comb begin
    deq_nxt = drop_nxt;
    for (int o = 0; o < OUTPUT_QTY; o++)
      for (int i = 0; i < INPUT_QTY; i++)
        if (win_valid[o] && win_idx[o] == SRC_W'(i))
          deq_nxt[i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid <= '0;
      grant_input <= '0;
      deq         <= '0;
      drop        <= '0;
    end else begin
      grant_valid <= win_valid;
      deq         <= deq_nxt;
      drop        <= drop_nxt;
      for (int o = 0; o < OUTPUT_QTY; o++)
        if (win_valid[o])
          grant_input[o] <= win_idx[o];
    end
  end

endmodule

// File: tb/tb_switch_rr_scheduler.sv
// Directed bench for switch_rr_scheduler: an 8x8 instance plus an 8x6 instance for drops.
module tb_switch_rr_scheduler;

  logic clk = 1'b0;
  logic reset;

  logic [7:0]      req_valid;
  logic [7:0][2:0] req_dest;
  logic [7:0]      out_ready;
  logic [7:0]      grant_valid;
  logic [7:0][2:0] grant_input;
  logic [7:0]      deq;
  logic [7:0]      drop;

  logic [7:0]      req_valid6;
  logic [7:0][2:0] req_dest6;
  logic [5:0]      out_ready6;
  logic [5:0]      grant_valid6;
  logic [5:0][2:0] grant_input6;
  logic [7:0]      deq6;
  logic [7:0]      drop6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  switch_rr_scheduler #(.INPUT_QTY(8), .OUTPUT_QTY(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_dest(req_dest),
    .out_ready(out_ready), .grant_valid(grant_valid), .grant_input(grant_input),
    .deq(deq), .drop(drop)
  );

  switch_rr_scheduler #(.INPUT_QTY(8), .OUTPUT_QTY(6)) dut6 (
    .clk(clk), .reset(reset), .req_valid(req_valid6), .req_dest(req_dest6),
    .out_ready(out_ready6), .grant_valid(grant_valid6), .grant_input(grant_input6),
    .deq(deq6), .drop(drop6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid  = '0;
    req_dest   = '0;
    out_ready  = '1;
    req_valid6 = '0;
    req_dest6  = '0;
    out_ready6 = '1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  logic [7:0]      rot_valid [6];
  logic [2:0]      rot_gi    [6];
  logic [7:0]      rot_deq   [6];
  logic [7:0][2:0] par_gi;

  initial begin
    reset = 1'b1;
    idle();
    // Reset held 3 cycles with every input requesting output 0.
    req_valid = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_gv", 32'(grant_valid), 32'h00);
      chk("rst_deq", 32'(deq), 32'h00);
      chk("rst_drop", 32'(drop), 32'h00);
      chk("rst_gi", 32'(grant_input), 32'h0);
    end
    reset = 1'b0;
    tick();
    chk("first_gv", 32'(grant_valid), 32'h01);
    chk("first_gi0", 32'(grant_input[0]), 32'd0);
    chk("first_deq", 32'(deq), 32'h01);
    tick();
    chk("second_gi0", 32'(grant_input[0]), 32'd1);
    chk("second_deq", 32'(deq), 32'h02);
    // Reset mid-operation cancels grants and restarts pointers.
    reset = 1'b1;
    tick();
    chk("midrst_gv", 32'(grant_valid), 32'h00);
    chk("midrst_deq", 32'(deq), 32'h00);
    reset = 1'b0;
    tick();
    chk("midrst_gi0", 32'(grant_input[0]), 32'd0);
    chk("midrst_deq2", 32'(deq), 32'h01);

    // Rotation among inputs 0, 3, 5 on output 2 with an empty-cycle FIFO model.
    do_reset();
    req_dest[0] = 3'd2;
    req_dest[3] = 3'd2;
    req_dest[5] = 3'd2;
    rot_valid = '{8'h29, 8'h29, 8'h28, 8'h21, 8'h09, 8'h28};
    rot_gi    = '{3'd0, 3'd3, 3'd5, 3'd0, 3'd3, 3'd5};
    rot_deq   = '{8'h01, 8'h08, 8'h20, 8'h01, 8'h08, 8'h20};
    for (int k = 0; k < 6; k++) begin
      req_valid = rot_valid[k];
      tick();
      chk("rot_gv", 32'(grant_valid), 32'h04);
      chk("rot_gi2", 32'(grant_input[2]), 32'(rot_gi[k]));
      chk("rot_deq", 32'(deq), 32'(rot_deq[k]));
    end

    // Backpressure on output 4 while output 5 keeps flowing.
    do_reset();
    req_dest[1] = 3'd4;
    req_dest[2] = 3'd4;
    req_dest[3] = 3'd5;
    req_valid   = 8'h0E;
    out_ready   = 8'hEF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_gv", 32'(grant_valid), (k % 2 == 0) ? 32'h20 : 32'h00);
      chk("bp_deq", 32'(deq), (k % 2 == 0) ? 32'h08 : 32'h00);
    end
    out_ready = 8'hFF;
    req_valid = 8'h06;
    tick();
    chk("bp_rel_gv", 32'(grant_valid), 32'h10);
    chk("bp_rel_gi4", 32'(grant_input[4]), 32'd1);
    chk("bp_rel_deq", 32'(deq), 32'h02);
    tick();
    chk("bp_next_gi4", 32'(grant_input[4]), 32'd2);
    chk("bp_next_deq", 32'(deq), 32'h04);

    // Parallel: input i targets output 7-i.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_dest[i] = 3'(7 - i);
      par_gi[i]   = 3'(7 - i);
    end
    req_valid = 8'hFF;
    tick();
    chk("par_gv", 32'(grant_valid), 32'hFF);
    chk("par_gi", 32'(grant_input), 32'(par_gi));
    chk("par_deq", 32'(deq), 32'hFF);

    // Pointer wrap on output 0.
    do_reset();
    req_valid = 8'h40;
    tick();
    chk("wrap_gi0_a", 32'(grant_input[0]), 32'd6);
    chk("wrap_deq_a", 32'(deq), 32'h40);
    req_valid = 8'h84;
    tick();
    chk("wrap_gi0_b", 32'(grant_input[0]), 32'd7);
    chk("wrap_deq_b", 32'(deq), 32'h80);
    tick();
    chk("wrap_gi0_c", 32'(grant_input[0]), 32'd2);
    chk("wrap_deq_c", 32'(deq), 32'h04);

    // Drop of out-of-range destinations on the 6-output instance.
    do_reset();
    req_dest6[0] = 3'd7;
    req_dest6[1] = 3'd0;
    req_valid6   = 8'h03;
    tick();
    chk("drop_drop", 32'(drop6), 32'h01);
    chk("drop_deq", 32'(deq6), 32'h03);
    chk("drop_gv", 32'(grant_valid6), 32'h01);
    chk("drop_gi0", 32'(grant_input6[0]), 32'd1);
    tick();
    chk("drop_mask_drop", 32'(drop6), 32'h00);
    chk("drop_mask_deq", 32'(deq6), 32'h00);
    chk("drop_mask_gv", 32'(grant_valid6), 32'h00);
    req_dest6[0] = 3'd6;
    req_valid6   = 8'h01;
    tick();
    chk("drop6_drop", 32'(drop6), 32'h01);
    chk("drop6_deq", 32'(deq6), 32'h01);
    chk("drop6_gv", 32'(grant_valid6), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
